eth_tx_pkt_buffer: RTL and testbench
====================================

Name: eth_tx_pkt_buffer

Overview:
- Store-and-forward transmit packet buffer that sits directly upstream of each 10G MAC channel's tx AXI-Stream port (tx0/tx1). One instance per channel, clocked by that channel's tx_clk_out.
- Guarantees the MAC never sees a mid-frame tvalid gap (MAC underrun).
- Drops errored or oversize frames.
- Zero-pads runt frames to the minimum payload length; the MAC appends FCS.

Parameters:
- P_DEPTH, 512, data RAM depth in 64-bit words (power of 2).
- P_LEN_DEPTH, 16, committed-packet descriptor FIFO depth (power of 2).
- P_PAD_LENGTH, 60, minimum output frame length in bytes, excluding FCS.
- P_MAX_LENGTH, 9600, maximum accepted frame length in bytes; larger frames are dropped.

Ports:
- i_clk  in  1  MAC tx_clk_out, single clock domain.
- i_rst_n  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  1  upstream beat valid.
- s_axis_tready  out  1  equals ~descriptor_fifo_full.
- s_axis_tdata  in  64  upstream data, byte 0 in bits [7:0].
- s_axis_tkeep  in  8  contiguous LSB-first; all-ones except on the tlast beat.
- s_axis_tlast  in  1  end of frame.
- s_axis_tuser  in  1  frame error, sampled on the tlast beat.
- m_axis_tvalid  out  1  to MAC tx_axis_tvalid.
- m_axis_tready  in  1  from MAC tx_axis_tready.
- m_axis_tdata  out  64  to MAC.
- m_axis_tkeep  out  8  to MAC.
- m_axis_tlast  out  1  to MAC.
- m_axis_tuser  out  1  tied 0.
- o_drop  out  1  one-cycle pulse per dropped frame.
- o_drop_cnt  out  16  saturating count of dropped frames.
- o_pkt_cnt  out  16  wrapping count of forwarded frames.

Behaviour:
- Reset: all pointers 0, FIFOs empty, FSM in IDLE. All outputs 0 except s_axis_tready, which is 1.
- Write side: each accepted beat writes {data, keep, last} at wr_ptr, increments wr_ptr and accumulates byte_cnt (16-bit) = byte_cnt + popcount(keep).
- Overflow: if RAM free space is 0 mid-frame, set bad_flag and stop writing. Still accept, but discard, the rest of the frame.
- On the tlast beat, drop when any of the following holds: bad_flag, tuser=1, or final byte_cnt > P_MAX_LENGTH.
  - Drop: wr_ptr rewinds to commit_ptr; o_drop pulses the next cycle; o_drop_cnt increments, saturating at 0xFFFF.
  - Otherwise: commit_ptr <= wr_ptr+1 and push byte_cnt into the descriptor FIFO.
- byte_cnt and bad_flag clear after every tlast.
- Read-side free-space accounting uses commit_ptr vs rd_ptr plus in-flight writes, so uncommitted data is never read.
- Read FSM states: IDLE, LOAD, SEND, PAD.
  - IDLE: if descriptor FIFO is non-empty, pop the length into rem_len and go to LOAD.
  - LOAD: issue the RAM read (1-cycle latency) and fill the output register.
  - SEND: m_axis_tvalid=1 continuously. On each handshake, prefetch the next word so valid never drops within a frame. When the stored last word is accepted:
    - if length >= P_PAD_LENGTH, it goes out with tlast=1;
    - otherwise it goes out with keep forced to 0xFF, bytes above the original keep zeroed, tlast=0, and the FSM enters PAD.
  - PAD: emit zero words. The final word has keep = (1 << (P_PAD_LENGTH mod 8)) - 1 (0x0F for 60) and tlast=1.
    - If P_PAD_LENGTH is a multiple of 8, keep is 0xFF.
    - If the original last word already reaches past byte P_PAD_LENGTH-1 but is short, keep is trimmed to exactly P_PAD_LENGTH bytes with tlast=1 and PAD is skipped.
- After tlast is accepted: o_pkt_cnt increments and the FSM returns to IDLE. The next frame's tvalid may assert after IDLE→LOAD, so there are at least 2 idle cycles between frames.
- Latency: m_axis_tvalid asserts at most 3 cycles after acceptance of a committed tlast beat when the buffer was empty.
- When m_axis_tready=0, m_axis_* holds stable.
- Pointer wrap uses an extra MSB for full/empty. Simultaneous commit and pop is legal. A write in the same cycle as the rewind is impossible because rewind occurs on the tlast beat itself.
- Reset mid-frame: the partially transmitted frame is abandoned and all state is cleared immediately (asynchronous).

Decomposition:
- Package eth_tx_buf_pkg holds:
  - constants: word width 64, keep width 8, byte-count width 16;
  - FSM state encoding localparams;
  - a popcount8 function.
- Sub-module: eth_tx_len_fifo, a synchronous FWFT FIFO of 16-bit descriptors, depth P_LEN_DEPTH.
- The data RAM is an inferred simple-dual-port array in the top.

Test Plan:
- 128-byte frame (16 full words), m_axis_tready=1 → 16 beats with tvalid never gapped, tlast on beat 16, o_pkt_cnt=1, tvalid within 3 cycles of input tlast.
- 3-byte frame (keep 0x07, data 0xAABBCC) → 8 beats: beat0 keep 0xFF with bytes 3..7 = 0, beats 1–6 zero, beat7 keep 0x0F with tlast.
- 9601-byte frame, then a 64-byte frame → o_drop pulses once, o_drop_cnt=1, only the 64-byte frame appears at the output.
- Frame with tuser=1 on tlast, then a good frame → errored frame absent, good frame intact, no RAM leak (free space restored).
- Random m_axis_tready toggling (50%) over 200 random-length frames → output stream equals a scoreboard of padded good frames, with no tvalid gap inside any frame.
- Fill P_LEN_DEPTH 64-byte frames with m_axis_tready=0 → s_axis_tready drops to 0. Release tready → all 16 frames drain in order.

Source files
------------

// File: rtl/eth_tx_buf_pkg.sv
// Shared widths, read-FSM state encoding and helpers for the tx packet buffer.
package eth_tx_buf_pkg;

   localparam int W_DATA = 64;
   localparam int W_KEEP = 8;
   localparam int W_BCNT = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_PAD  = 2'd3
   } rd_state_t;

   // Number of valid bytes flagged in a keep vector.
   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/eth_tx_len_fifo.sv
// First-word-fall-through FIFO of committed frame lengths.
module eth_tx_len_fifo
   import eth_tx_buf_pkg::*;
#(
   parameter int P_DEPTH = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              push,
   input  logic [W_BCNT-1:0] wdata,
   input  logic              pop,
   output logic [W_BCNT-1:0] rdata,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(P_DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [W_BCNT-1:0] mem [P_DEPTH];
   logic [AW:0]       wp;
   logic [AW:0]       rp;
   logic              do_push;
   logic              do_pop;

   assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign empty   = (wp == rp);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rp[AW-1:0]];

   // Descriptor storage write.
   always_ff @(posedge i_clk) begin
      if (do_push) mem[wp[AW-1:0]] <= wdata;
   end

   // Pointer update; extra MSB separates full from empty.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + PTR_ONE;
         if (do_pop)  rp <= rp + PTR_ONE;
      end
   end

endmodule

// File: rtl/eth_tx_pkt_buffer.sv
// Store-and-forward tx buffer in front of a 10G MAC: drops bad/oversize
// frames, zero-pads runts, and never gaps tvalid inside a frame.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a committed frame; pops its length
//   LOAD    | first word of the frame moves from RAM into output register
//   SEND    | streaming stored words, next word prefetched on handshake
//   PAD     | streaming zero words up to the minimum frame length
module eth_tx_pkt_buffer
   import eth_tx_buf_pkg::*;
#(
   parameter int P_DEPTH      = 512,
   parameter int P_LEN_DEPTH  = 16,
   parameter int P_PAD_LENGTH = 60,
   parameter int P_MAX_LENGTH = 9600
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic [W_DATA-1:0] s_axis_tdata,
   input  logic [W_KEEP-1:0] s_axis_tkeep,
   input  logic              s_axis_tlast,
   input  logic              s_axis_tuser,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [W_DATA-1:0] m_axis_tdata,
   output logic [W_KEEP-1:0] m_axis_tkeep,
   output logic              m_axis_tlast,
   output logic              m_axis_tuser,
   output logic              o_drop,
   output logic [15:0]       o_drop_cnt,
   output logic [15:0]       o_pkt_cnt
);

   localparam int AW      = $clog2(P_DEPTH);
   localparam int LW      = W_DATA + W_KEEP + 1;
   localparam int PAD_REM = P_PAD_LENGTH % 8;
   localparam logic [W_KEEP-1:0] PAD_LAST_KEEP =
      (PAD_REM == 0) ? 8'hFF : W_KEEP'((1 << PAD_REM) - 1);
   localparam logic [W_BCNT-1:0] PAD_LAST_IDX = W_BCNT'((P_PAD_LENGTH - 1) / 8);
   localparam logic [W_BCNT-1:0] PAD_FLOOR    = W_BCNT'(((P_PAD_LENGTH - 1) / 8) * 8);
   localparam logic [W_BCNT-1:0] PAD_LEN      = W_BCNT'(P_PAD_LENGTH);
   localparam logic [W_BCNT-1:0] MAX_LEN      = W_BCNT'(P_MAX_LENGTH);
   localparam logic [W_BCNT-1:0] BC_ONE       = W_BCNT'(1);
   localparam logic [AW:0]       RAM_WORDS    = (AW+1)'(P_DEPTH);
   localparam logic [AW:0]       PTR_ONE      = (AW+1)'(1);

   logic [LW-1:0]     ram [P_DEPTH];
   logic [LW-1:0]     ram_q;
   logic [AW:0]       wr_ptr, commit_ptr, rd_ptr, rd_ptr_nxt, used;
   logic              ram_full, s_acc, wr_en, frame_drop, desc_push;
   logic [W_BCNT:0]   bc_sum;
   logic [W_BCNT-1:0] byte_cnt, byte_cnt_nxt;
   logic              bad_flag;
   logic              desc_full, desc_empty, desc_pop;
   logic [W_BCNT-1:0] desc_len;

   rd_state_t         state, state_nxt;
   logic [W_DATA-1:0] q_data, sh_data;
   logic [W_KEEP-1:0] q_keep, sh_keep;
   logic              q_last, sh_tlast;
   logic              m_slast, m_hs, ld_ram, ld_pad, pkt_done;
   logic [W_BCNT-1:0] rem_len, pad_idx, last_idx, pad_sel;

   assign s_axis_tready = ~desc_full;
   assign s_acc         = s_axis_tvalid & s_axis_tready;
   // Occupancy counts uncommitted words too, so an in-flight frame can never overwrite unread data.
   assign used          = wr_ptr - rd_ptr;
   assign ram_full      = (used == RAM_WORDS);
   assign wr_en         = s_acc & ~bad_flag & ~ram_full;
   assign bc_sum        = {1'b0, byte_cnt} + (W_BCNT+1)'(popcount8(s_axis_tkeep));
   assign byte_cnt_nxt  = bc_sum[W_BCNT] ? '1 : bc_sum[W_BCNT-1:0];
   assign frame_drop    = s_acc & s_axis_tlast &
                          (bad_flag | ram_full | s_axis_tuser | (byte_cnt_nxt > MAX_LEN));
   assign desc_push     = s_acc & s_axis_tlast & ~frame_drop;
   assign m_axis_tuser  = 1'b0;

   // Data RAM write port.
   always_ff @(posedge i_clk) begin
      if (wr_en) ram[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
   end

   // Look-ahead read: ram_q always holds the word at the current rd_ptr.
   always_ff @(posedge i_clk) begin
      ram_q <= ram[rd_ptr_nxt[AW-1:0]];
   end

   // Write-side pointers, byte count, overflow flag and drop accounting.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr     <= '0;
         commit_ptr <= '0;
         byte_cnt   <= '0;
         bad_flag   <= 1'b0;
         o_drop     <= 1'b0;
         o_drop_cnt <= '0;
      end else begin
         o_drop <= frame_drop;
         if (frame_drop && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
         if (s_acc) begin
            if (s_axis_tlast) begin
               byte_cnt <= '0;
               bad_flag <= 1'b0;
               if (frame_drop) begin
                  wr_ptr <= commit_ptr;
               end else begin
                  wr_ptr     <= wr_ptr + PTR_ONE;
                  commit_ptr <= wr_ptr + PTR_ONE;
               end
            end else begin
               byte_cnt <= byte_cnt_nxt;
               if (ram_full) bad_flag <= 1'b1;
               if (wr_en)    wr_ptr   <= wr_ptr + PTR_ONE;
            end
         end
      end
   end

   eth_tx_len_fifo #(.P_DEPTH(P_LEN_DEPTH)) u_len_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .push    (desc_push),
      .wdata   (byte_cnt_nxt),
      .pop     (desc_pop),
      .rdata   (desc_len),
      .full    (desc_full),
      .empty   (desc_empty)
   );

   assign {q_last, q_keep, q_data} = ram_q;
   assign m_hs       = m_axis_tvalid & m_axis_tready;
   assign rd_ptr_nxt = ld_ram ? rd_ptr + PTR_ONE : rd_ptr;
   assign last_idx   = (rem_len - BC_ONE) >> 3;
   assign pad_sel    = ((state == ST_SEND) ? last_idx : pad_idx) + BC_ONE;

   // Shape a stored word for output: runt tails become full words or are trimmed to the pad length.
   always_comb begin
      sh_data  = '0;
      sh_keep  = q_keep;
      sh_tlast = 1'b0;
      for (int i = 0; i < W_KEEP; i++) sh_data[8*i +: 8] = q_keep[i] ? q_data[8*i +: 8] : 8'h00;
      if (q_last) begin
         if (rem_len >= PAD_LEN) begin
            sh_tlast = 1'b1;
         end else if (rem_len > PAD_FLOOR) begin
            sh_keep  = PAD_LAST_KEEP;
            sh_tlast = 1'b1;
         end else begin
            sh_keep  = '1;
         end
      end
   end

   // Read FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Read FSM next state and control strobes.
   always_comb begin
      state_nxt     = state;
      desc_pop      = 1'b0;
      ld_ram        = 1'b0;
      ld_pad        = 1'b0;
      pkt_done      = 1'b0;
      m_axis_tvalid = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!desc_empty) begin
               desc_pop  = 1'b1;
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            ld_ram    = 1'b1;
            state_nxt = ST_SEND;
         end
         ST_SEND: begin
            m_axis_tvalid = 1'b1;
            if (m_hs) begin
               if (m_axis_tlast) begin
                  pkt_done  = 1'b1;
                  state_nxt = ST_IDLE;
               end else if (m_slast) begin
                  ld_pad    = 1'b1;
                  state_nxt = ST_PAD;
               end else begin
                  ld_ram    = 1'b1;
               end
            end
         end
         ST_PAD: begin
            m_axis_tvalid = 1'b1;
            if (m_hs) begin
               if (m_axis_tlast) begin
                  pkt_done  = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  ld_pad    = 1'b1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output register, read pointer, frame length and forwarded-frame count.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_ptr       <= '0;
         m_axis_tdata <= '0;
         m_axis_tkeep <= '0;
         m_axis_tlast <= 1'b0;
         m_slast      <= 1'b0;
         rem_len      <= '0;
         pad_idx      <= '0;
         o_pkt_cnt    <= '0;
      end else begin
         rd_ptr <= rd_ptr_nxt;
         if (desc_pop) rem_len <= desc_len;
         if (ld_ram) begin
            m_axis_tdata <= sh_data;
            m_axis_tkeep <= sh_keep;
            m_axis_tlast <= sh_tlast;
            m_slast      <= q_last;
         end else if (ld_pad) begin
            m_axis_tdata <= '0;
            m_axis_tkeep <= (pad_sel == PAD_LAST_IDX) ? PAD_LAST_KEEP : 8'hFF;
            m_axis_tlast <= (pad_sel == PAD_LAST_IDX);
            m_slast      <= 1'b0;
            pad_idx      <= pad_sel;
         end
         if (pkt_done) o_pkt_cnt <= o_pkt_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_eth_tx_pkt_buffer.sv
// Directed and randomised frames against a byte-level frame model.
module tb_eth_tx_pkt_buffer;

   localparam int PAD  = 60;
   localparam int MAXL = 9600;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [63:0] s_axis_tdata = '0;
   logic [7:0]  s_axis_tkeep = '0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tuser = 1'b0;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic [63:0] m_axis_tdata;
   logic [7:0]  m_axis_tkeep;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic        o_drop;
   logic [15:0] o_drop_cnt;
   logic [15:0] o_pkt_cnt;

   eth_tx_pkt_buffer dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .o_drop        (o_drop),
      .o_drop_cnt    (o_drop_cnt),
      .o_pkt_cnt     (o_pkt_cnt)
   );

   always #5 i_clk = ~i_clk;

   int          vectors = 0;
   int          miscompares = 0;
   int          exp_pkts = 0;
   int          exp_drops = 0;
   int          drops_seen = 0;
   int          cyc = 0;
   int          tlast_cyc = 0;
   int          first_valid_cyc = -1;
   bit          rdy_rand = 1'b0;
   bit          rdy_hold = 1'b1;
   bit          in_frame = 1'b0;
   bit          stall_prev = 1'b0;
   logic [63:0] prev_data = '0;
   logic [9:0]  prev_ctl = '0;
   beat_t       exp_q[$];
   beat_t       obs_q[$];
   logic [7:0]  fbytes[$];

   always @(posedge i_clk) cyc <= cyc + 1;

   function automatic logic [63:0] kmask(input logic [7:0] k);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
      return m;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic abort(input string name);
      miscompares++;
      $display("FAIL %s: wait budget expired", name);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "bench aborted");
   endtask

   // Frame model: good frames are zero-extended to PAD bytes and cut into 8-byte beats.
   task automatic model_push(input bit user);
      int         n;
      logic [7:0] p[$];
      n = fbytes.size();
      if (user || n > MAXL) begin
         exp_drops++;
         return;
      end
      p = fbytes;
      while (p.size() < PAD) p.push_back(8'h00);
      for (int b = 0; b * 8 < p.size(); b++) begin
         beat_t e;
         e = '0;
         for (int i = 0; i < 8; i++) begin
            if (b * 8 + i < p.size()) begin
               e.data[8*i +: 8] = p[b * 8 + i];
               e.keep[i] = 1'b1;
            end
         end
         e.last = ((b + 1) * 8 >= p.size());
         exp_q.push_back(e);
      end
      exp_pkts++;
   endtask

   task automatic fill_rand(input int len);
      fbytes.delete();
      for (int i = 0; i < len; i++) fbytes.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic send_frame(input bit user);
      int n;
      int nb;
      int w;
      n  = fbytes.size();
      nb = (n + 7) / 8;
      model_push(user);
      for (int b = 0; b < nb; b++) begin
         logic [63:0] d;
         logic [7:0]  k;
         d = '0;
         k = '0;
         for (int i = 0; i < 8; i++) begin
            if (b * 8 + i < n) begin
               d[8*i +: 8] = fbytes[b * 8 + i];
               k[i] = 1'b1;
            end
         end
         @(negedge i_clk);
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = d;
         s_axis_tkeep  = k;
         s_axis_tlast  = (b == nb - 1);
         s_axis_tuser  = user && (b == nb - 1);
         w = 0;
         while (!s_axis_tready) begin
            @(negedge i_clk);
            w++;
            if (w > 20000) abort("s_tready_wait");
         end
         @(posedge i_clk);
         #1;
         s_axis_tvalid = 1'b0;
      end
      tlast_cyc = cyc;
      fbytes.delete();
   endtask

   task automatic wait_drain(input string name);
      int w;
      w = 0;
      while (exp_q.size() != 0) begin
         @(negedge i_clk);
         w++;
         if (w > 50000) abort(name);
      end
      repeat (4) @(negedge i_clk);
   endtask

   // Ready driver plus output compare: scoreboard, hold-while-stalled, no gap inside a frame.
   always @(negedge i_clk) begin
      beat_t o;
      beat_t e;
      m_axis_tready = rdy_rand ? ($urandom_range(0, 1) == 1) : rdy_hold;
      if (i_rst_n) begin
         if (o_drop) drops_seen++;
         if (stall_prev) begin
            check("hold_data", m_axis_tdata, prev_data);
            check("hold_ctl", {54'd0, m_axis_tvalid, m_axis_tkeep, m_axis_tlast},
                  {54'd0, prev_ctl});
         end
         if (in_frame) check("no_gap_tvalid", 64'(m_axis_tvalid), 64'd1);
         if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (m_axis_tvalid && m_axis_tready) begin
            o.data = m_axis_tdata & kmask(m_axis_tkeep);
            o.keep = m_axis_tkeep;
            o.last = m_axis_tlast;
            obs_q.push_back(o);
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL extra_beat: got data %0h keep %0h last %0b, expected no beat",
                        o.data, o.keep, o.last);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", o.data, e.data);
               check("beat_keep", 64'(o.keep), 64'(e.keep));
               check("beat_last", 64'(o.last), 64'(e.last));
               check("beat_tuser", 64'(m_axis_tuser), 64'd0);
            end
            in_frame = !m_axis_tlast;
         end
         stall_prev = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_ctl   = {m_axis_tvalid, m_axis_tkeep, m_axis_tlast};
      end
   end

   initial begin
      repeat (3) @(negedge i_clk);
      check("rst_s_tready", 64'(s_axis_tready), 64'd1);
      check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_m_tdata", m_axis_tdata, 64'd0);
      check("rst_drop", 64'(o_drop), 64'd0);
      check("rst_drop_cnt", 64'(o_drop_cnt), 64'd0);
      check("rst_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
      i_rst_n = 1'b1;
      repeat (2) @(negedge i_clk);

      // 128-byte frame, sink always ready
      first_valid_cyc = -1;
      obs_q.delete();
      fill_rand(128);
      send_frame(1'b0);
      wait_drain("t1_drain");
      check("t1_latency_le3",
            64'((first_valid_cyc - tlast_cyc) >= 1 && (first_valid_cyc - tlast_cyc) <= 3), 64'd1);
      check("t1_beats", 64'(obs_q.size()), 64'd16);
      check("t1_pkt_cnt", 64'(o_pkt_cnt), 64'd1);

      // 3-byte runt: padded to 60 bytes
      obs_q.delete();
      fbytes.delete();
      fbytes.push_back(8'hCC);
      fbytes.push_back(8'hBB);
      fbytes.push_back(8'hAA);
      send_frame(1'b0);
      wait_drain("t2_drain");
      check("t2_beats", 64'(obs_q.size()), 64'd8);
      if (obs_q.size() == 8) begin
         check("t2_b0_data", obs_q[0].data, 64'h0000_0000_00AA_BBCC);
         check("t2_b0_keep", 64'(obs_q[0].keep), 64'hFF);
         check("t2_b0_last", 64'(obs_q[0].last), 64'd0);
         check("t2_b3_data", obs_q[3].data, 64'd0);
         check("t2_b7_keep", 64'(obs_q[7].keep), 64'h0F);
         check("t2_b7_last", 64'(obs_q[7].last), 64'd1);
      end
      check("t2_pkt_cnt", 64'(o_pkt_cnt), 64'd2);

      // oversize frame dropped, following frame intact
      obs_q.delete();
      fill_rand(9601);
      send_frame(1'b0);
      fill_rand(64);
      send_frame(1'b0);
      wait_drain("t3_drain");
      check("t3_drop_pulses", 64'(drops_seen), 64'd1);
      check("t3_drop_cnt", 64'(o_drop_cnt), 64'd1);
      check("t3_beats", 64'(obs_q.size()), 64'd8);
      check("t3_pkt_cnt", 64'(o_pkt_cnt), 64'd3);

      // errored frame dropped; a full-RAM frame afterwards proves the space came back
      fill_rand(100);
      send_frame(1'b1);
      fill_rand(40);
      send_frame(1'b0);
      wait_drain("t4_drain");
      check("t4_drop_cnt", 64'(o_drop_cnt), 64'd2);
      fill_rand(4096);
      send_frame(1'b0);
      wait_drain("t4_full_ram_drain");
      check("t4_pkt_cnt", 64'(o_pkt_cnt), 64'd5);
      check("t4_drop_cnt_after", 64'(o_drop_cnt), 64'd2);

      // backpressure: one frame held by the reader plus 16 queued fills the descriptor FIFO
      rdy_hold = 1'b0;
      for (int f = 0; f < 17; f++) begin
         fill_rand(64);
         send_frame(1'b0);
      end
      @(negedge i_clk);
      check("t5_s_tready_low", 64'(s_axis_tready), 64'd0);
      check("t5_pkt_cnt_held", 64'(o_pkt_cnt), 64'd5);
      rdy_hold = 1'b1;
      wait_drain("t5_drain");
      check("t5_pkt_cnt", 64'(o_pkt_cnt), 64'd22);
      check("t5_s_tready_back", 64'(s_axis_tready), 64'd1);

      // random lengths, random sink readiness, occasional errored frames
      rdy_rand = 1'b1;
      for (int f = 0; f < 200; f++) begin
         fill_rand(int'($urandom_range(1, 200)));
         send_frame($urandom_range(0, 9) == 0);
         repeat ($urandom_range(0, 3)) @(negedge i_clk);
      end
      wait_drain("t6_drain");
      rdy_rand = 1'b0;
      rdy_hold = 1'b1;
      repeat (4) @(negedge i_clk);
      check("t6_pkt_cnt", 64'(o_pkt_cnt), 64'(16'(exp_pkts)));
      check("t6_drop_cnt", 64'(o_drop_cnt), 64'(16'(exp_drops)));
      check("t6_drop_pulses", 64'(drops_seen), 64'(exp_drops));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
